// File: rtl/ctrl_pkg.sv
// Shared types and constants for the multi-cycle control sequencer.
// State encoding, ALU select codes, funct codes, default R-type opcode.
package ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC,
    S_WB
  } state_t;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SLL = 3'b011;
  localparam logic [2:0] ALU_SUB = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_MUL = 3'b110;
  localparam logic [2:0] ALU_XOR = 3'b111;

  localparam logic [2:0] F_ADD = 3'd0;
  localparam logic [2:0] F_SUB = 3'd1;
  localparam logic [2:0] F_OR  = 3'd2;
  localparam logic [2:0] F_AND = 3'd3;
  localparam logic [2:0] F_SLL = 3'd4;
  localparam logic [2:0] F_SRL = 3'd5;
  localparam logic [2:0] F_MUL = 3'd6;
  localparam logic [2:0] F_XOR = 3'd7;

  localparam logic [3:0] DEF_R_OPCODE = 4'b1100;

endpackage

// File: rtl/ctrl_funct_decode.sv
// Combinational funct decoder: ALU select, multiply flag, legality.
// Undefined instructions decode to select 0 so the sequencer can load it directly.
module ctrl_funct_decode
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W = 4,
  parameter int FUNCT_W = 4,
  parameter int ALU_CTRL_W = 3,
  parameter logic [OPCODE_W-1:0] R_OPCODE = OPCODE_W'(DEF_R_OPCODE)
) (
  input  logic [OPCODE_W-1:0]   opcode,
  input  logic [FUNCT_W-1:0]    funct,
  output logic [ALU_CTRL_W-1:0] alu_sel,
  output logic                  is_mul,
  output logic                  legal
);

  logic [2:0] sel;

  // Map the low funct bits to an ALU code; legality gates everything.
  always_comb begin
    sel = ALU_AND;
    unique case (funct[2:0])
      F_ADD: sel = ALU_ADD;
      F_SUB: sel = ALU_SUB;
      F_OR:  sel = ALU_OR;
      F_AND: sel = ALU_AND;
      F_SLL: sel = ALU_SLL;
      F_SRL: sel = ALU_SRL;
      F_MUL: sel = ALU_MUL;
      F_XOR: sel = ALU_XOR;
      default: sel = ALU_AND;
    endcase
  end

  assign legal = (opcode == R_OPCODE)
              && (32'(funct) < 32'd8);
  assign is_mul = legal
               && (funct[2:0] == F_MUL);
  assign alu_sel = legal ? ALU_CTRL_W'(sel)
                         : '0;

endmodule

// File: rtl/mc_control_seq.sv
// Multi-cycle control sequencer: IDLE -> DECODE -> EXEC(n) -> WB.
// Define MC_CONTROL_ILLEGAL_TRAP_EN to pulse 'illegal' on undefined instructions.
module mc_control_seq
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W = 4,
  parameter int FUNCT_W = 4,
  parameter int ALU_CTRL_W = 3,
  parameter logic [OPCODE_W-1:0] R_OPCODE = OPCODE_W'(DEF_R_OPCODE),
  parameter int MUL_CYCLES = 3,
  parameter int CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [OPCODE_W-1:0]   opcode,
  input  logic [FUNCT_W-1:0]    funct,
  input  logic                  flush,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic                  regwrite_control,
  output logic                  busy,
  output logic                  illegal,
  output logic [CNT_W-1:0]      retired
);

  localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES - 1);

  state_t state, state_nx;

  logic [OPCODE_W-1:0]   op_q;
  logic [FUNCT_W-1:0]    fn_q;
  logic [ALU_CTRL_W-1:0] dec_sel;
  logic                  dec_mul;
  logic                  dec_legal;
  logic [CW-1:0]         cnt;
  logic                  accept;
  logic                  dec_go;

  ctrl_funct_decode #(
    .OPCODE_W(OPCODE_W),
    .FUNCT_W(FUNCT_W),
    .ALU_CTRL_W(ALU_CTRL_W),
    .R_OPCODE(R_OPCODE)
  ) u_dec (
    .opcode(op_q),
    .funct(fn_q),
    .alu_sel(dec_sel),
    .is_mul(dec_mul),
    .legal(dec_legal)
  );

  assign accept = (state == S_IDLE) && instr_valid;
  assign dec_go = (state == S_DECODE) && !flush;

  assign instr_ready = (state == S_IDLE);
  assign busy = (state != S_IDLE);
  assign regwrite_control = (state == S_WB);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else state <= state_nx;
  end

  // Next-state logic; flush aborts any in-flight step.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (instr_valid) state_nx = S_DECODE;
      end
      S_DECODE: begin
        if (flush) state_nx = S_IDLE;
        else if (dec_legal) state_nx = S_EXEC;
        else state_nx = S_IDLE;
      end
      S_EXEC: begin
        if (flush) state_nx = S_IDLE;
        else if (cnt == '0) state_nx = S_WB;
      end
      S_WB: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Capture the instruction fields on accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q <= '0;
      fn_q <= '0;
    end else if (accept) begin
      op_q <= opcode;
      fn_q <= funct;
    end
  end

  // ALU select loads once in DECODE and holds through WB and flushes.
  always_ff @(posedge clk) begin
    if (reset) alu_control <= '0;
    else if (dec_go) alu_control <= dec_sel;
  end

  // Execute-window down-counter.
  always_ff @(posedge clk) begin
    if (reset) cnt <= '0;
    else if (state == S_DECODE) cnt <= dec_mul ? MUL_LOAD : '0;
    else if (state == S_EXEC && cnt != '0) cnt <= cnt - 1'b1;
  end

  // Retired count: every WB commits, even when flushed in that cycle.
  always_ff @(posedge clk) begin
    if (reset) retired <= '0;
    else if (state == S_WB) retired <= retired + 1'b1;
  end

`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
  // One-cycle pulse in the cycle after an undefined instruction decodes.
  always_ff @(posedge clk) begin
    if (reset) illegal <= 1'b0;
    else illegal <= dec_go && !dec_legal;
  end
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_mc_control_seq.sv
// Directed self-checking bench for mc_control_seq.
// Checks sit 1ns after each rising edge; inputs change at the same point.
module tb_mc_control_seq;

  logic       clk;
  logic       reset;
  logic       instr_valid;
  logic       instr_ready;
  logic [3:0] opcode;
  logic [3:0] funct;
  logic       flush;
  logic [2:0] alu_control;
  logic       regwrite_control;
  logic       busy;
  logic       illegal;
  logic [7:0] retired;

  int n_cmp = 0;
  int n_err = 0;

`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
  localparam logic ILL_EXP = 1'b1;
`else
  localparam logic ILL_EXP = 1'b0;
`endif

  mc_control_seq dut (
    .clk(clk),
    .reset(reset),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .opcode(opcode),
    .funct(funct),
    .flush(flush),
    .alu_control(alu_control),
    .regwrite_control(regwrite_control),
    .busy(busy),
    .illegal(illegal),
    .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, 32'(instr_ready), 32'd1);
    chk({tag, "_alu"}, 32'(alu_control), 32'd0);
    chk({tag, "_regw"}, 32'(regwrite_control), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_ill"}, 32'(illegal), 32'd0);
    chk({tag, "_ret"}, 32'(retired), 32'd0);
  endtask

  task automatic issue(input logic [3:0] op,
                       input logic [3:0] fn);
    opcode = op;
    funct = fn;
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
  endtask

  int acc;
  int wbs;
  int bad;

  initial begin
    reset = 1'b1;
    instr_valid = 1'b0;
    opcode = 4'h0;
    funct = 4'h0;
    flush = 1'b0;
    step();
    step();
    chk_reset_vals("rst");
    reset = 1'b0;
    step();

    // ADD: accept at T, now in T+1
    issue(4'hC, 4'd0);
    chk("add_t1_busy", 32'(busy), 32'd1);
    chk("add_t1_ready", 32'(instr_ready), 32'd0);
    chk("add_t1_regw", 32'(regwrite_control), 32'd0);
    step();
    chk("add_t2_alu", 32'(alu_control), 32'h2);
    chk("add_t2_regw", 32'(regwrite_control), 32'd0);
    step();
    chk("add_t3_regw", 32'(regwrite_control), 32'd1);
    chk("add_t3_alu", 32'(alu_control), 32'h2);
    chk("add_t3_ready", 32'(instr_ready), 32'd0);
    step();
    chk("add_t4_regw", 32'(regwrite_control), 32'd0);
    chk("add_t4_ret", 32'(retired), 32'd1);
    chk("add_t4_ready", 32'(instr_ready), 32'd1);

    // MUL: EXEC T+2..T+4, WB T+5
    issue(4'hC, 4'd6);
    step();
    chk("mul_t2_alu", 32'(alu_control), 32'h6);
    chk("mul_t2_regw", 32'(regwrite_control), 32'd0);
    step();
    chk("mul_t3_alu", 32'(alu_control), 32'h6);
    chk("mul_t3_regw", 32'(regwrite_control), 32'd0);
    step();
    chk("mul_t4_busy", 32'(busy), 32'd1);
    chk("mul_t4_regw", 32'(regwrite_control), 32'd0);
    step();
    chk("mul_t5_regw", 32'(regwrite_control), 32'd1);
    chk("mul_t5_alu", 32'(alu_control), 32'h6);
    step();
    chk("mul_t6_ret", 32'(retired), 32'd2);
    chk("mul_t6_ready", 32'(instr_ready), 32'd1);

    // funct 9: undefined
    issue(4'hC, 4'd9);
    chk("f9_t1_busy", 32'(busy), 32'd1);
    chk("f9_t1_ill", 32'(illegal), 32'd0);
    step();
    chk("f9_t2_busy", 32'(busy), 32'd0);
    chk("f9_t2_ill", 32'(illegal), 32'(ILL_EXP));
    chk("f9_t2_regw", 32'(regwrite_control), 32'd0);
    chk("f9_t2_alu", 32'(alu_control), 32'd0);
    step();
    chk("f9_t3_ill", 32'(illegal), 32'd0);
    chk("f9_t3_ret", 32'(retired), 32'd2);

    // wrong opcode: undefined too
    issue(4'h3, 4'd0);
    step();
    chk("op3_t2_ill", 32'(illegal), 32'(ILL_EXP));
    chk("op3_t2_busy", 32'(busy), 32'd0);
    step();
    chk("op3_t3_ret", 32'(retired), 32'd2);

    // flush in 2nd EXEC cycle of MUL
    issue(4'hC, 4'd6);
    step();
    step();
    chk("fl_t3_busy", 32'(busy), 32'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_t4_busy", 32'(busy), 32'd0);
    chk("fl_t4_ready", 32'(instr_ready), 32'd1);
    chk("fl_t4_regw", 32'(regwrite_control), 32'd0);
    chk("fl_t4_alu", 32'(alu_control), 32'h6);
    step();
    chk("fl_t5_regw", 32'(regwrite_control), 32'd0);
    chk("fl_t5_ret", 32'(retired), 32'd2);

    // ADD after flush completes normally
    issue(4'hC, 4'd0);
    step();
    chk("fa_t2_alu", 32'(alu_control), 32'h2);
    step();
    chk("fa_t3_regw", 32'(regwrite_control), 32'd1);
    step();
    chk("fa_t4_ret", 32'(retired), 32'd3);

    // flush+valid in IDLE: accepted (XOR)
    flush = 1'b1;
    issue(4'hC, 4'd7);
    flush = 1'b0;
    chk("fi_t1_busy", 32'(busy), 32'd1);
    step();
    step();
    chk("fi_t3_regw", 32'(regwrite_control), 32'd1);
    chk("fi_t3_alu", 32'(alu_control), 32'h7);
    step();
    chk("fi_t4_ret", 32'(retired), 32'd4);

    // flush during WB still commits (SUB)
    issue(4'hC, 4'd1);
    step();
    step();
    chk("fw_t3_regw", 32'(regwrite_control), 32'd1);
    chk("fw_t3_alu", 32'(alu_control), 32'h4);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fw_t4_ret", 32'(retired), 32'd5);
    chk("fw_t4_busy", 32'(busy), 32'd0);

    // 257 back-to-back ADDs from a fresh reset
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("b2b_ret0", 32'(retired), 32'd0);
    opcode = 4'hC;
    funct = 4'd0;
    instr_valid = 1'b1;
    acc = 0;
    wbs = 0;
    bad = 0;
    for (int cyc = 0; cyc < 2000 && wbs < 257; cyc++) begin
      if (instr_ready) acc++;
      step();
      if (regwrite_control && instr_ready) bad++;
      if (regwrite_control) wbs++;
      if (wbs == 257) instr_valid = 1'b0;
    end
    instr_valid = 1'b0;
    chk("b2b_wbs", 32'(wbs), 32'd257);
    step();
    chk("b2b_acc", 32'(acc), 32'd257);
    chk("b2b_bad", 32'(bad), 32'd0);
    chk("b2b_ret", 32'(retired), 32'd1);
    chk("b2b_busy", 32'(busy), 32'd0);

    // reset with flush mid-EXEC of MUL
    issue(4'hC, 4'd6);
    step();
    chk("rx_t2_alu", 32'(alu_control), 32'h6);
    reset = 1'b1;
    flush = 1'b1;
    step();
    reset = 1'b0;
    flush = 1'b0;
    chk_reset_vals("rx");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mc_control_seq.md
# mc_control_seq

Multi-cycle control sequencer for the 4-bit RISC-V-style core; replaces the single-cycle combinational decoder. Accepts one instruction's opcode/funct per handshake, steps it through DECODE, EXECUTE and WRITEBACK, and holds a registered ALU select for the whole operation. Gives multiply a configurable multi-cycle execute window and asserts the register-file write strobe for exactly one cycle. Sits between the instruction register and the ALU/register file.

## Interface
- OPCODE_W, 4, opcode field width
- FUNCT_W, 4, funct field width
- ALU_CTRL_W, 3, ALU select width (≥3)
- R_OPCODE, 4'b1100, R-type opcode value
- MUL_CYCLES, 3, execute cycles for MUL (≥1); all other ops take 1
- CNT_W, 8, retired-instruction counter width
- clk  in  1  clock; all logic is rising-edge
- reset  in  1  synchronous, active-high
- instr_valid  in  1  opcode/funct valid
- instr_ready  out  1  sequencer can accept
- opcode  in  OPCODE_W  instruction opcode
- funct  in  FUNCT_W  instruction funct
- flush  in  1  synchronous abort of in-flight instruction
- alu_control  out  ALU_CTRL_W  registered ALU select
- regwrite_control  out  1  one-cycle register-file write strobe
- busy  out  1  instruction in flight
- illegal  out  1  one-cycle pulse, undefined instruction (macro-gated)
- retired  out  CNT_W  count of writebacks

## Operation
- States: IDLE, DECODE, EXEC, WB.
- IDLE: instr_ready=1. On instr_valid: capture opcode/funct → DECODE. Otherwise stay.
- DECODE: for R_OPCODE, funct maps 0→010 ADD, 1→100 SUB, 2→001 OR, 3→000 AND, 4→011 SLL, 5→101 SRL, 6→110 MUL, 7→111 XOR; register into alu_control; load exec counter (MUL_CYCLES-1 for MUL, else 0) → EXEC.
- Undefined = opcode ≠ R_OPCODE, or funct ≥ 8. Undefined instructions: alu_control←0, no writeback, → IDLE (see Configuration).
- EXEC: counter decrements each cycle; at 0 → WB. alu_control held stable throughout.
- WB: regwrite_control=1, retired+=1 (wraps modulo 2^CNT_W) → IDLE.
- busy = state ≠ IDLE. instr_ready = state == IDLE; no new accept in WB cycle.
- flush in any non-IDLE state: → IDLE next cycle, no regwrite, retired unchanged, alu_control held. flush in WB: the WB cycle's regwrite has already been asserted that cycle (commits). flush in IDLE ignored; flush+instr_valid in IDLE: instruction accepted.
- reset overrides everything, including flush.

## Timing
- Reset values: state IDLE, instr_ready 1, alu_control 0, regwrite_control 0, busy 0, illegal 0, retired 0.
- Accept at edge T (valid&&ready). DECODE T+1, EXEC T+2 … T+1+n, WB T+2+n, IDLE T+3+n, where n = MUL_CYCLES for MUL, 1 otherwise.
- ADD: regwrite_control high in cycle T+3 only; instr_ready high again T+4.
- alu_control valid from cycle T+2 through WB.
- Undefined: DECODE at T+1, IDLE at T+2; illegal pulses in cycle T+2.
- Back-to-back throughput: one instruction per n+3 cycles.

## Configuration
- MC_CONTROL_ILLEGAL_TRAP_EN defined: illegal pulses one cycle on an undefined instruction; no writeback.
- Undefined: illegal tied 0; undefined instructions silently retire as NOPs (no regwrite, no counter increment). Sequencing otherwise identical.

## Structure
- Package ctrl_pkg: state enum, ALU select constants (ALU_ADD…ALU_XOR), funct constants, default R_OPCODE.
- Sub-module ctrl_funct_decode: combinational funct → {alu_control, is_mul, legal}; the sequencer registers its outputs in DECODE.

## Test plan
- Reset, then ADD (opcode C, funct 0) accepted at T → alu_control=010 from T+2, regwrite_control=1 only at T+3, retired=1, instr_ready=1 at T+4.
- MUL (funct 6), MUL_CYCLES=3 → EXEC T+2..T+4, regwrite at T+5, alu_control=110 held T+2..T+5.
- funct 9 with macro on → illegal=1 at T+2, no regwrite, retired unchanged; macro off → illegal stays 0.
- flush asserted in 2nd EXEC cycle of MUL → IDLE next cycle, no regwrite, retired unchanged; following ADD completes normally.
- 2^CNT_W+1 back-to-back ADDs with instr_valid held 1 → retired wraps to 1; accepts only when instr_ready=1, none in WB.
- reset asserted mid-EXEC with flush → all outputs return to reset values next cycle.
